alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single 32-bit ALU/compare unit between two requesters (port 0: main datapath,
//  port 1: auxiliary unit, e.g. address/debug engine). Accepts one operation at a time via
//  valid/ready, drives the ALU for one cycle, registers result and branch flag, returns them
//  on a valid/ready response channel tagged with the requester id. Sits between requesters and ALU.
// PARAMETERS
//  DW    32  operand/result width
//  OPW   4   ALU opcode width (ALUOp)
//  CMPW  3   compare opcode width (CMPOp)
// PORTS
//  clk          in   1     system clock, rising edge
//  reset        in   1     asynchronous, active-low reset (0 = in reset)
//  req0_valid   in   1     port 0 request valid
//  req0_ready   out  1     port 0 request accepted this cycle
//  req0_a/b     in   DW    port 0 operands A, B
//  req0_aluop   in   OPW   port 0 ALU opcode
//  req0_cmpop   in   CMPW  port 0 compare opcode
//  req1_*       --   --    identical set for port 1
//  resp_valid   out  1     response holds valid result
//  resp_ready   in   1     consumer accepts response
//  resp_data    out  DW    registered ALU result
//  resp_branch  out  1     registered compare flag
//  resp_id      out  1     requester that issued the op (0/1)
//  alu_a/b      out  DW    ALU operand drive
//  alu_aluop    out  OPW   ALU opcode drive
//  alu_cmpop    out  CMPW  compare opcode drive
//  alu_res      in   DW    ALU combinational result
//  alu_branch   in   1     ALU combinational compare flag
//  busy         out  1     FSM not in IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, last_grant=1, resp_valid=0, resp_data=0, resp_branch=0,
//    resp_id=0, all alu_* = 0, req*_ready=0, busy=0. Reset mid-operation discards the op silently.
//  - FSM IDLE -> EXEC -> RESP -> IDLE. Throughput: one op per 3 cycles min.
//  - IDLE: if any reqN_valid, pick winner; reqN_ready=1 (combinational) for winner only; latch
//    operands, opcodes, id on that edge; next state EXEC. No valid: stay IDLE, both ready=0.
//  - Pick: one valid -> that port. Both valid -> port != last_grant (round-robin); last_grant
//    updates on grant. After reset port 0 wins first tie.
//  - EXEC: alu_* = latched values for exactly this cycle; at edge capture alu_res/alu_branch into
//    resp_data/resp_branch, resp_valid<=1; next RESP. Outside EXEC alu_* = 0.
//  - RESP: resp_valid=1, resp_data/branch/id stable until resp_ready=1; on handshake
//    resp_valid<=0, next IDLE. New requests wait (ready=0) in EXEC and RESP.
//  - Data passed unmodified: undefined opcodes yield whatever ALU returns; no width conversion.
//  - Request-to-response latency: 2 cycles after accept edge (resp_valid high in cycle acc+2).
//  - Requester dropping valid before ready: no effect, nothing latched.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: ties always go to port 0; last_grant unused (held at reset value).
//  Undefined (default): round-robin tie-break as above.
// STRUCTURE
//  - const.v (shared): ALUOp codes ADD/SUB/OR/LUI, CMPOp_beq, plus new FSM state codes
//    ARB_IDLE=2'd0, ARB_EXEC=2'd1, ARB_RESP=2'd2.
//  - One sub-module: alu_rr_pick (inputs valid0, valid1, last_grant; outputs grant_vld,
//    grant_id), contains the ALU_ARB_FIXED_PRIO_EN switch.
// TESTING
//  1 reset=0 mid-EXEC -> all outputs 0 immediately; after release port 0 wins first tie.
//  2 port0 ADD a=5,b=7 alone -> req0_ready 1 cycle, 2 cycles later resp_data=12, resp_id=0.
//  3 both valid every op, resp_ready=1 -> grant order 0,1,0,1 (fixed-prio build: 0,0,0,0).
//  4 port1 beq a=b=0xDEADBEEF -> resp_branch=1; a=1,b=2 -> resp_branch=0.
//  5 resp_ready=0 for 5 cycles on LUI b=0x1234 -> resp_data=0x12340000 held, req ready=0 throughout.
//  6 SUB a=0,b=1 -> resp_data=0xFFFFFFFF (wrap), alu_* return to 0 after EXEC.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU opcode/compare codes and the arbiter FSM state encoding.
// Imported by alu_share_arbiter and alu_rr_pick.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_OR  = 4'd2;
  localparam logic [3:0] ALUOP_LUI = 4'd3;

  localparam logic [2:0] CMPOP_BEQ = 3'd0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-port grant picker. Ties go round-robin against last_grant, or always to
// port 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_id
);

  assign grant_vld = valid0 | valid1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_id          = ~valid0;
`else
  // On a tie the port that did not win last time gets the ALU.
  assign grant_id = (valid0 & valid1) ? ~last_grant : valid1;
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU/compare unit between two requesters: IDLE -> EXEC -> RESP.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed port-0 priority on ties.
module alu_share_arbiter #(
  parameter int DW   = 32,
  parameter int OPW  = 4,
  parameter int CMPW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [OPW-1:0]  req0_aluop,
  input  logic [CMPW-1:0] req0_cmpop,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [OPW-1:0]  req1_aluop,
  input  logic [CMPW-1:0] req1_cmpop,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [DW-1:0]   resp_data,
  output logic            resp_branch,
  output logic            resp_id,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_aluop,
  output logic [CMPW-1:0] alu_cmpop,
  input  logic [DW-1:0]   alu_res,
  input  logic            alu_branch,
  output logic            busy
);
  import alu_share_arbiter_pkg::*;

  arb_state_t      state, state_nxt;
  logic            last_grant;
  logic            grant_vld, grant_id;
  logic            load;
  logic [DW-1:0]   lat_a, lat_b;
  logic [OPW-1:0]  lat_aluop;
  logic [CMPW-1:0] lat_cmpop;

  alu_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ARB_IDLE: if (grant_vld) begin
        state_nxt = ARB_EXEC;
        load      = 1'b1;
      end
      ARB_EXEC: state_nxt = ARB_RESP;
      ARB_RESP: if (resp_ready) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Ready is forced low while reset is asserted, even though IDLE with a valid
  // request would otherwise raise it.
  assign req0_ready = reset & load & ~grant_id;
  assign req1_ready = reset & load &  grant_id;
  assign resp_valid = (state == ARB_RESP);
  assign busy       = (state != ARB_IDLE);
  assign alu_a      = (state == ARB_EXEC) ? lat_a     : '0;
  assign alu_b      = (state == ARB_EXEC) ? lat_b     : '0;
  assign alu_aluop  = (state == ARB_EXEC) ? lat_aluop : '0;
  assign alu_cmpop  = (state == ARB_EXEC) ? lat_cmpop : '0;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; the operand latches are reset too because resp_id
  // and friends are visible outputs with defined reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      last_grant  <= 1'b1;
      lat_a       <= '0;
      lat_b       <= '0;
      lat_aluop   <= '0;
      lat_cmpop   <= '0;
      resp_data   <= '0;
      resp_branch <= 1'b0;
      resp_id     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        lat_a     <= grant_id ? req1_a     : req0_a;
        lat_b     <= grant_id ? req1_b     : req0_b;
        lat_aluop <= grant_id ? req1_aluop : req0_aluop;
        lat_cmpop <= grant_id ? req1_cmpop : req0_cmpop;
        resp_id   <= grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= grant_id;
`endif
      end
      if (state == ARB_EXEC) begin
        resp_data   <= alu_res;
        resp_branch <= alu_branch;
      end
    end
  end

endmodule
